// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : issue_scoreboard
// Purpose  : Decode-to-execute issue controller. Keeps a pending-write counter
//            per MIPS GPR, stalls decoded instructions that read a register
//            with a pending write (RAW) or would saturate a counter (WAW),
//            and holds a store-conditional in DRAIN until every older writer
//            has written back.
// Ports    : clk, rst_n (synchronous, active-low)
//            dec_*            decoded instruction fields and valid
//            ex_ready         ID/EX register can accept
//            dec_ready        decoder may advance (combinational)
//            issue_valid      instruction issued this cycle (combinational)
//            wb_valid/wb_addr writeback completion
//            flush            clears all tracking (wb_err kept)
//            inflight         pending writer count (registered)
//            busy_mask        per-register pending flag (registered, bit 0 = 0)
//            wb_err           sticky writeback-without-pending error
// Options  : ISSUE_SCOREBOARD_STATS_EN adds stat_raw_stalls,
//            stat_drain_cycles, stat_full_stalls (saturating counters).
// Revision : 1.0 - initial release
// ============================================================================
module issue_scoreboard #(
   parameter int CNT_W        = 2,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              dec_valid,
   input  logic                              dec_uses_rs,
   input  logic [4:0]                        dec_rs_addr,
   input  logic                              dec_uses_rt,
   input  logic [4:0]                        dec_rt_addr,
   input  logic                              dec_uses_rw,
   input  logic [4:0]                        dec_rw_addr,
   input  logic                              dec_is_sc,
   input  logic                              ex_ready,
   output logic                              dec_ready,
   output logic                              issue_valid,
   input  logic                              wb_valid,
   input  logic [4:0]                        wb_addr,
   input  logic                              flush,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
   output logic [31:0]                       busy_mask,
   output logic                              wb_err
`ifdef ISSUE_SCOREBOARD_STATS_EN
   ,
   output logic [31:0]                       stat_raw_stalls,
   output logic [31:0]                       stat_drain_cycles,
   output logic [31:0]                       stat_full_stalls
`endif
);

   localparam int               IW         = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [IW-1:0]    C_INFL_MAX = IW'(MAX_INFLIGHT);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt [32];
   logic [IW-1:0]    r_inflight;
   logic [31:0]      r_busy;
   logic             r_wb_err;

   logic [CNT_W-1:0] w_cnt_next [32];
   logic [31:0]      w_busy_next;
   logic [IW-1:0]    w_inflight_next;
   logic             w_raw;
   logic             w_sat;
   logic             w_full;
   logic             w_sc_wait;
   logic             w_can_issue;
   logic             w_inc;
   logic             w_wb_hit;
   logic             w_wb_spurious;

   // Hazards are judged on registered state only; a writeback in the same
   // cycle does not release a stalled reader until the following cycle.
   assign w_raw     = (dec_uses_rs & r_busy[dec_rs_addr]) |
                      (dec_uses_rt & r_busy[dec_rt_addr]);
   assign w_sat     = dec_uses_rw & (r_cnt[dec_rw_addr] == C_CNT_MAX);
   assign w_full    = dec_uses_rw & (r_inflight >= C_INFL_MAX);
   assign w_sc_wait = dec_is_sc & (r_inflight != '0);

   // rst_n gates the handshake so nothing issues while reset is asserted.
   assign w_can_issue = rst_n & (r_state == ST_RUN) & ~w_raw & ~w_sat &
                        ~w_full & ~w_sc_wait & ~flush;
   assign dec_ready   = ex_ready & w_can_issue;
   assign issue_valid = dec_valid & dec_ready;

   // r0 is never tracked: neither issue nor writeback to it touches state.
   assign w_inc         = issue_valid & dec_uses_rw & (dec_rw_addr != 5'd0);
   assign w_wb_hit      = wb_valid & (wb_addr != 5'd0) & (r_cnt[wb_addr] != '0);
   assign w_wb_spurious = wb_valid & (wb_addr != 5'd0) & (r_cnt[wb_addr] == '0);

   // Issue and writeback to the same register cancel out naturally.
   assign w_inflight_next = r_inflight + IW'(w_inc) - IW'(w_wb_hit);

   always_comb begin
      for (int r = 0; r < 32; r++) begin
         w_cnt_next[r] = r_cnt[r];
         if (w_inc && (dec_rw_addr == 5'(r))) begin
            w_cnt_next[r] = w_cnt_next[r] + CNT_W'(1);
         end
         if (w_wb_hit && (wb_addr == 5'(r))) begin
            w_cnt_next[r] = w_cnt_next[r] - CNT_W'(1);
         end
         w_busy_next[r] = (w_cnt_next[r] != '0);
      end
      w_busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < 32; r++) begin
            r_cnt[r] <= '0;
         end
         r_inflight <= '0;
         r_busy     <= '0;
         r_wb_err   <= 1'b0;
         r_state    <= ST_RUN;
      end else if (flush) begin
         // Issue and writeback in the flush cycle are discarded; the error
         // flag survives so software can still observe it.
         for (int r = 0; r < 32; r++) begin
            r_cnt[r] <= '0;
         end
         r_inflight <= '0;
         r_busy     <= '0;
         r_state    <= ST_RUN;
      end else begin
         r_cnt      <= w_cnt_next;
         r_inflight <= w_inflight_next;
         r_busy     <= w_busy_next;
         r_wb_err   <= r_wb_err | w_wb_spurious;
         case (r_state)
            ST_RUN: begin
               if (dec_valid && dec_is_sc && (r_inflight != '0)) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Leave once the last older writer retires, or if the
               // decoder withdraws the sc.
               if (!dec_valid || (w_inflight_next == '0)) begin
                  r_state <= ST_RUN;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign inflight  = r_inflight;
   assign busy_mask = r_busy;
   assign wb_err    = r_wb_err;

`ifdef ISSUE_SCOREBOARD_STATS_EN
   logic [31:0] r_stat_raw;
   logic [31:0] r_stat_drain;
   logic [31:0] r_stat_full;
   logic        w_drain_cause;
   logic        w_raw_cause;
   logic        w_full_cause;

   // One cause per stalled cycle, DRAIN first, then RAW, then full.
   assign w_drain_cause = dec_valid & ((r_state == ST_DRAIN) | w_sc_wait);
   assign w_raw_cause   = dec_valid & ~w_drain_cause & w_raw;
   assign w_full_cause  = dec_valid & ~w_drain_cause & ~w_raw & w_full;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stat_raw   <= '0;
         r_stat_drain <= '0;
         r_stat_full  <= '0;
      end else begin
         if (w_raw_cause && (r_stat_raw != '1)) begin
            r_stat_raw <= r_stat_raw + 32'd1;
         end
         if (w_drain_cause && (r_stat_drain != '1)) begin
            r_stat_drain <= r_stat_drain + 32'd1;
         end
         if (w_full_cause && (r_stat_full != '1)) begin
            r_stat_full <= r_stat_full + 32'd1;
         end
      end
   end

   assign stat_raw_stalls   = r_stat_raw;
   assign stat_drain_cycles = r_stat_drain;
   assign stat_full_stalls  = r_stat_full;
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_scoreboard
// Purpose  : Self-checking bench for issue_scoreboard. A count-based model of
//            the scoreboard is compared against the DUT every cycle; directed
//            sequences pin specific literal values, followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_scoreboard;

   localparam int CNT_W        = 2;
   localparam int MAX_INFLIGHT = 8;
   localparam int IW           = $clog2(MAX_INFLIGHT + 1);
   localparam int CNT_MAX      = (1 << CNT_W) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          dec_valid;
   logic          dec_uses_rs;
   logic [4:0]    dec_rs_addr;
   logic          dec_uses_rt;
   logic [4:0]    dec_rt_addr;
   logic          dec_uses_rw;
   logic [4:0]    dec_rw_addr;
   logic          dec_is_sc;
   logic          ex_ready;
   logic          dec_ready;
   logic          issue_valid;
   logic          wb_valid;
   logic [4:0]    wb_addr;
   logic          flush;
   logic [IW-1:0] inflight;
   logic [31:0]   busy_mask;
   logic          wb_err;

   always #5 clk = ~clk;

   issue_scoreboard #(
      .CNT_W        (CNT_W),
      .MAX_INFLIGHT (MAX_INFLIGHT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .dec_valid   (dec_valid),
      .dec_uses_rs (dec_uses_rs),
      .dec_rs_addr (dec_rs_addr),
      .dec_uses_rt (dec_uses_rt),
      .dec_rt_addr (dec_rt_addr),
      .dec_uses_rw (dec_uses_rw),
      .dec_rw_addr (dec_rw_addr),
      .dec_is_sc   (dec_is_sc),
      .ex_ready    (ex_ready),
      .dec_ready   (dec_ready),
      .issue_valid (issue_valid),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .flush       (flush),
      .inflight    (inflight),
      .busy_mask   (busy_mask),
      .wb_err      (wb_err)
   );

   // ---------------- reference model ----------------
   int checks = 0;
   int errors = 0;
   int m_cnt [32];
   int m_infl;
   bit m_err;
   bit m_drain;
   bit m_started = 1'b0;
   bit m_last_stall = 1'b0;
   int pend [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_ready();
      bit raw, sat, full, scw;
      if (!rst_n || flush || m_drain) return 1'b0;
      raw  = (dec_uses_rs && m_cnt[dec_rs_addr] > 0) || (dec_uses_rt && m_cnt[dec_rt_addr] > 0);
      sat  = dec_uses_rw && (m_cnt[dec_rw_addr] >= CNT_MAX);
      full = dec_uses_rw && (m_infl >= MAX_INFLIGHT);
      scw  = dec_is_sc && (m_infl != 0);
      return ex_ready && !raw && !sat && !full && !scw;
   endfunction

   always @(posedge clk) begin : p_model
      int old_wb;
      int old_infl;
      bit iss;
      iss          = dec_valid && exp_ready();
      m_last_stall = rst_n && dec_valid && !iss;
      m_started    = 1'b1;
      if (!rst_n) begin
         for (int r = 0; r < 32; r++) m_cnt[r] = 0;
         m_infl  = 0;
         m_err   = 1'b0;
         m_drain = 1'b0;
      end else if (flush) begin
         for (int r = 0; r < 32; r++) m_cnt[r] = 0;
         m_infl  = 0;
         m_drain = 1'b0;
      end else begin
         old_infl = m_infl;
         old_wb   = m_cnt[wb_addr];
         if (iss && dec_uses_rw && dec_rw_addr != 5'd0) begin
            m_cnt[dec_rw_addr]++;
            m_infl++;
         end
         if (wb_valid && wb_addr != 5'd0) begin
            if (old_wb > 0) begin
               m_cnt[wb_addr]--;
               m_infl--;
            end else begin
               m_err = 1'b1;
            end
         end
         if (!m_drain) begin
            if (dec_valid && dec_is_sc && old_infl != 0) m_drain = 1'b1;
         end else if (!dec_valid || m_infl == 0) begin
            m_drain = 1'b0;
         end
      end
   end

   always @(negedge clk) begin : p_compare
      logic [31:0] eb;
      if (m_started) begin
         eb = '0;
         for (int r = 1; r < 32; r++) eb[r] = (m_cnt[r] != 0);
         chk("model dec_ready",   32'(dec_ready),   32'(exp_ready()));
         chk("model issue_valid", 32'(issue_valid), 32'(dec_valid && exp_ready()));
         chk("model inflight",    32'(inflight),    32'(m_infl));
         chk("model busy_mask",   busy_mask,        eb);
         chk("model wb_err",      32'(wb_err),      32'(m_err));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dec(input bit v, input bit urs, input int rs, input bit urt, input int rt,
                          input bit urw, input int rw, input bit sc);
      dec_valid   = v;
      dec_uses_rs = urs;
      dec_rs_addr = 5'(rs);
      dec_uses_rt = urt;
      dec_rt_addr = 5'(rt);
      dec_uses_rw = urw;
      dec_rw_addr = 5'(rw);
      dec_is_sc   = sc;
   endtask

   task automatic set_wb(input bit v, input int a);
      wb_valid = v;
      wb_addr  = 5'(a);
   endtask

   initial begin
      rst_n    = 1'b0;
      flush    = 1'b0;
      ex_ready = 1'b1;
      set_wb(0, 0);
      set_dec(1, 1, 1, 1, 2, 1, 3, 0);

      // Reset held three cycles with a valid instruction present.
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset dec_ready", 32'(dec_ready), 32'd0);
      chk("reset inflight",  32'(inflight),  32'd0);
      chk("reset busy_mask", busy_mask,      32'd0);
      chk("reset wb_err",    32'(wb_err),    32'd0);

      // RAW on r5.
      tick();
      rst_n = 1'b1;
      set_dec(1, 0, 0, 0, 0, 1, 5, 0);
      @(negedge clk);
      chk("raw first issue", 32'(issue_valid), 32'd1);
      tick();
      set_dec(1, 1, 5, 0, 0, 1, 6, 0);
      set_wb(1, 5);
      @(negedge clk);
      chk("raw stall",       32'(issue_valid), 32'd0);
      chk("raw busy r5",     busy_mask,        32'h0000_0020);
      chk("raw inflight",    32'(inflight),    32'd1);
      tick();
      set_wb(0, 0);
      @(negedge clk);
      chk("raw busy clear",  busy_mask,        32'd0);
      chk("raw issue after", 32'(issue_valid), 32'd1);
      tick();
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      set_wb(1, 6);
      tick();
      set_wb(0, 0);

      // Saturation on r7.
      set_dec(1, 0, 0, 0, 0, 1, 7, 0);
      tick();
      tick();
      tick();
      set_wb(1, 7);
      @(negedge clk);
      chk("sat stall",       32'(issue_valid), 32'd0);
      chk("sat inflight",    32'(inflight),    32'd3);
      chk("sat busy r7",     busy_mask,        32'h0000_0080);
      tick();
      @(negedge clk);
      chk("sat issue+wb",    32'(issue_valid), 32'd1);
      tick();
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("sat cancel infl", 32'(inflight),    32'd2);
      tick();
      tick();
      set_wb(0, 0);
      @(negedge clk);
      chk("sat drained",     32'(inflight),    32'd0);

      // sc drain behind two writers.
      set_dec(1, 0, 0, 0, 0, 1, 10, 0);
      tick();
      set_dec(1, 0, 0, 0, 0, 1, 11, 0);
      tick();
      set_dec(1, 1, 2, 1, 12, 1, 12, 1);
      @(negedge clk);
      chk("sc wait ready",   32'(dec_ready),   32'd0);
      chk("sc wait infl",    32'(inflight),    32'd2);
      tick();
      set_wb(1, 10);
      @(negedge clk);
      chk("drain ready a",   32'(dec_ready),   32'd0);
      tick();
      set_wb(1, 11);
      @(negedge clk);
      chk("drain ready b",   32'(dec_ready),   32'd0);
      tick();
      set_wb(0, 0);
      @(negedge clk);
      chk("sc issues",       32'(issue_valid), 32'd1);
      tick();
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("sc inflight",     32'(inflight),    32'd1);
      set_wb(1, 12);
      tick();
      set_wb(0, 0);

      // Flush with four writers pending and a simultaneous writeback.
      for (int r = 3; r <= 6; r++) begin
         set_dec(1, 0, 0, 0, 0, 1, r, 0);
         tick();
      end
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("pre-flush infl",  32'(inflight),    32'd4);
      tick();
      flush = 1'b1;
      set_wb(1, 3);
      set_dec(1, 0, 0, 0, 0, 1, 8, 0);
      @(negedge clk);
      chk("flush no issue",  32'(issue_valid), 32'd0);
      tick();
      flush = 1'b0;
      set_wb(0, 0);
      set_dec(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("flush inflight",  32'(inflight),    32'd0);
      chk("flush busy",      busy_mask,        32'd0);
      chk("flush wb_err",    32'(wb_err),      32'd0);

      // Spurious writebacks.
      set_wb(1, 0);
      tick();
      set_wb(0, 0);
      @(negedge clk);
      chk("wb r0 no err",    32'(wb_err),      32'd0);
      set_wb(1, 9);
      tick();
      set_wb(0, 0);
      @(negedge clk);
      chk("spurious err",    32'(wb_err),      32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("err after flush", 32'(wb_err),      32'd1);

      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;

      // Random traffic; the decoder holds its fields while stalled.
      for (int c = 0; c < 4000; c++) begin
         int wb_pct;
         wb_pct   = (c < 2000) ? 40 : 20;
         rst_n    = ($urandom_range(0, 299) != 0);
         flush    = ($urandom_range(0, 59) == 0);
         ex_ready = ($urandom_range(0, 9) < 8);
         if (dec_valid && m_last_stall) begin
            if ($urandom_range(0, 7) == 0) dec_valid = 1'b0;
         end else begin
            int rs, rt, rw;
            rs = $urandom_range(0, 7);
            rt = $urandom_range(0, 7);
            rw = $urandom_range(0, 7);
            set_dec($urandom_range(0, 9) < 7,
                    (rs != 0) && $urandom_range(0, 1) == 1, rs,
                    (rt != 0) && $urandom_range(0, 1) == 1, rt,
                    (rw != 0) && $urandom_range(0, 3) != 0, rw,
                    $urandom_range(0, 9) == 0);
         end
         if (!flush && $urandom_range(0, 99) < wb_pct) begin
            pend.delete();
            for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) pend.push_back(r);
            if (pend.size() == 0 || $urandom_range(0, 24) == 0)
               set_wb(1, $urandom_range(0, 15));
            else
               set_wb(1, pend[$urandom_range(0, pend.size() - 1)]);
         end else begin
            set_wb(0, 0);
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
